// File: rtl/deser_frame_p_if.sv
`default_nettype none
// ============================================================================
// Module   : deser_frame_p_if
// Brief    : Bus bundle between the RX sampler and the frame deserialiser.
//            par_calc exists only when DESER_PARITY_CALC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface deser_frame_p_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) ();
    logic                  deser_en;
    logic                  sampled_bit;
    logic                  clear;
    logic [CNT_W-1:0]      frame_len;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  busy;
`ifdef DESER_PARITY_CALC_EN
    logic                  par_calc;
`endif

    modport master (
        output deser_en, sampled_bit, clear, frame_len,
`ifdef DESER_PARITY_CALC_EN
        input  par_calc,
`endif
        input  P_DATA, data_valid, bit_cnt, busy
    );

    modport slave (
        input  deser_en, sampled_bit, clear, frame_len,
`ifdef DESER_PARITY_CALC_EN
        output par_calc,
`endif
        output P_DATA, data_valid, bit_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/deser_frame_p.sv
`default_nettype none
// ============================================================================
// Module   : deser_frame_p
// Brief    : Serial-to-parallel converter with runtime frame length and
//            selectable bit order. Define DESER_PARITY_CALC_EN for par_calc.
// Revision : 1.0 - initial release
// ============================================================================
module deser_frame_p #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    deser_frame_p_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_LEN_MAX = CNT_W'(DATA_WIDTH);

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_bit_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]      r_len, w_len_nxt;
    logic [CNT_W-1:0]      w_len_clamp, w_len_use, w_pos;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_shift_set;
    logic [DATA_WIDTH-1:0] r_pdata, w_pdata_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  w_last;

    // Lengths below 2 or above the word width fall back to a full word.
    assign w_len_clamp = ((bus.frame_len < CNT_W'(2)) || (bus.frame_len > c_LEN_MAX))
                         ? c_LEN_MAX : bus.frame_len;
    assign w_len_use   = (r_state == S_IDLE) ? w_len_clamp : r_len;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_pos = w_len_use - CNT_W'(1) - r_bit_cnt;
        end else begin : g_lsb_first
            assign w_pos = r_bit_cnt;
        end
    endgenerate

    assign w_shift_set = r_shift | (DATA_WIDTH'(bus.sampled_bit) << w_pos);
    assign w_last      = (r_bit_cnt == (w_len_use - CNT_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_len_nxt   = r_len;
        w_shift_nxt = r_shift;
        w_pdata_nxt = r_pdata;
        w_valid_nxt = 1'b0;
        if (bus.clear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
        end else if (bus.deser_en) begin
            case (r_state)
                S_IDLE: begin
                    w_len_nxt   = w_len_clamp;
                    w_shift_nxt = w_shift_set;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_COLLECT;
                end
                S_COLLECT: begin
                    if (w_last) begin
                        w_pdata_nxt = w_shift_set;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_shift_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_shift_nxt = w_shift_set;
                        w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_len     <= c_LEN_MAX;
            r_shift   <= '0;
            r_pdata   <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_shift   <= w_shift_nxt;
            r_pdata   <= w_pdata_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

`ifdef DESER_PARITY_CALC_EN
    logic r_par_run, r_par_calc, w_complete;

    assign w_complete = bus.deser_en & ~bus.clear & (r_state == S_COLLECT) & w_last;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_run  <= 1'b0;
            r_par_calc <= 1'b0;
        end else if (bus.clear) begin
            r_par_run  <= 1'b0;
        end else if (w_complete) begin
            r_par_calc <= r_par_run ^ bus.sampled_bit;
            r_par_run  <= 1'b0;
        end else if (bus.deser_en) begin
            r_par_run  <= r_par_run ^ bus.sampled_bit;
        end
    end

    assign bus.par_calc = r_par_calc;
`endif

    assign bus.P_DATA     = r_pdata;
    assign bus.data_valid = r_valid;
    assign bus.bit_cnt    = r_bit_cnt;
    assign bus.busy       = (r_bit_cnt != '0);

endmodule
`default_nettype wire
